// File: rtl/tetris_input_pkg.sv
// Shared key indices and repeat-FSM state type for the pushbutton front end.
package tetris_input_pkg;

  localparam int unsigned KEY_ROT   = 0;
  localparam int unsigned KEY_LEFT  = 1;
  localparam int unsigned KEY_RIGHT = 2;
  localparam int unsigned KEY_DOWN  = 3;
  localparam int unsigned NUM_KEYS  = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DAS_WAIT,
    ST_REPEAT
  } rep_state_t;

endpackage

// File: rtl/key_debounce.sv
// One pushbutton: 2-flop synchronizer, inversion to active-high, and a
// consecutive-sample debouncer. 'change' strobes in the cycle whose closing
// edge toggles 'held', so held-rise/held-fall strobes are change & ~held / change & held.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic key_n,
  output logic held,
  output logic change
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic          sample;

  assign sample = ~sync2;
  // Counter saturates at DEBOUNCE_CYCLES differing samples; the following edge commits.
  assign change = (cnt == CW'(DEBOUNCE_CYCLES));

  // Synchronize, count consecutive differing samples, toggle the accepted level.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      cnt   <= '0;
      held  <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      if (change) begin
        held <= ~held;
        cnt  <= '0;
      end else if (sample != held) begin
        cnt <= cnt + CW'(1);
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/key_move_ctrl.sv
// Pushbutton-to-move-request controller: four debounced keys, one-cycle
// registered move pulses. Define KEY_AUTOREPEAT_EN to build the DAS/ARR
// auto-repeat FSMs for left/right/down; without it every key pulses once per press.
module key_move_ctrl
  import tetris_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned DAS_DELAY       = 8000000,
  parameter int unsigned ARR_PERIOD      = 2500000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [3:0] KEY,
  output logic       move_left,
  output logic       move_right,
  output logic       move_down,
  output logic       rotate,
  output logic [3:0] held
);

  if (DEBOUNCE_CYCLES == 0 || DAS_DELAY == 0 || ARR_PERIOD == 0) begin : g_param_check
    $error("key_move_ctrl: DEBOUNCE_CYCLES, DAS_DELAY and ARR_PERIOD must be nonzero");
  end

  logic [NUM_KEYS-1:0] key_chg;
  logic [NUM_KEYS-1:0] key_rise;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .CLOCK_50(CLOCK_50),
      .reset   (reset),
      .key_n   (KEY[i]),
      .held    (held[i]),
      .change  (key_chg[i])
    );
  end

  assign key_rise = key_chg & ~held;

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned RPT_MAX  = (DAS_DELAY > ARR_PERIOD) ? DAS_DELAY : ARR_PERIOD;
  localparam int unsigned RW       = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
  localparam logic [RW-1:0] DAS_LOAD = RW'(DAS_DELAY - 1);
  localparam logic [RW-1:0] ARR_LOAD = RW'(ARR_PERIOD - 1);

  // Repeat channels: 0 = left, 1 = right, 2 = down.
  rep_state_t    state_q [3];
  rep_state_t    state_d [3];
  logic [RW-1:0] cnt_q   [3];
  logic [RW-1:0] cnt_d   [3];
  logic [2:0]    pulse_d;
  logic [2:0]    ch_rise;
  logic [2:0]    ch_fall;
  logic [2:0]    ch_hold;
  logic          lr_conflict;

  assign lr_conflict = held[KEY_LEFT] & held[KEY_RIGHT];
  assign ch_rise = {key_rise[KEY_DOWN], key_rise[KEY_RIGHT], key_rise[KEY_LEFT]};
  assign ch_fall = {key_chg[KEY_DOWN]  & held[KEY_DOWN],
                    key_chg[KEY_RIGHT] & held[KEY_RIGHT],
                    key_chg[KEY_LEFT]  & held[KEY_LEFT]};
  assign ch_hold = {1'b0, lr_conflict, lr_conflict};

  // Next-state and pulse decode; release wins over any due repeat.
  always_comb begin
    for (int unsigned c = 0; c < 3; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      pulse_d[c] = 1'b0;
      if (ch_fall[c]) begin
        state_d[c] = ST_IDLE;
        cnt_d[c]   = '0;
      end else begin
        case (state_q[c])
          ST_IDLE: begin
            if (ch_rise[c]) begin
              pulse_d[c] = 1'b1;
              state_d[c] = ST_DAS_WAIT;
              cnt_d[c]   = DAS_LOAD;
            end
          end
          ST_DAS_WAIT, ST_REPEAT: begin
            if (!ch_hold[c]) begin
              if (cnt_q[c] == '0) begin
                pulse_d[c] = 1'b1;
                state_d[c] = ST_REPEAT;
                cnt_d[c]   = ARR_LOAD;
              end else begin
                cnt_d[c] = cnt_q[c] - RW'(1);
              end
            end
          end
          default: begin
            state_d[c] = ST_IDLE;
            cnt_d[c]   = '0;
          end
        endcase
      end
    end
  end

  // State/counter registers and registered request pulses.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int unsigned c = 0; c < 3; c++) begin
        state_q[c] <= ST_IDLE;
        cnt_q[c]   <= '0;
      end
      move_left  <= 1'b0;
      move_right <= 1'b0;
      move_down  <= 1'b0;
      rotate     <= 1'b0;
    end else begin
      for (int unsigned c = 0; c < 3; c++) begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
      end
      move_left  <= pulse_d[0];
      move_right <= pulse_d[1];
      move_down  <= pulse_d[2];
      rotate     <= key_rise[KEY_ROT];
    end
  end
`else
  // Single pulse per debounced press on every key.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      move_left  <= 1'b0;
      move_right <= 1'b0;
      move_down  <= 1'b0;
      rotate     <= 1'b0;
    end else begin
      move_left  <= key_rise[KEY_LEFT];
      move_right <= key_rise[KEY_RIGHT];
      move_down  <= key_rise[KEY_DOWN];
      rotate     <= key_rise[KEY_ROT];
    end
  end
`endif

endmodule

// File: tb/tb_key_move_ctrl.sv
// Scoreboard bench for key_move_ctrl (DEBOUNCE_CYCLES=4, DAS_DELAY=20, ARR_PERIOD=5).
// Expected pulse vectors are {move_down, move_right, move_left, rotate}.
module tb_key_move_ctrl;

  localparam int unsigned DB  = 4;
  localparam int unsigned DAS = 20;
  localparam int unsigned ARR = 5;
  localparam int LAT = 7;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic [3:0] KEY      = 4'hF;
  logic       move_left;
  logic       move_right;
  logic       move_down;
  logic       rotate;
  logic [3:0] held;
  logic [3:0] pulses;

  key_move_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .DAS_DELAY      (DAS),
    .ARR_PERIOD     (ARR)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .KEY       (KEY),
    .move_left (move_left),
    .move_right(move_right),
    .move_down (move_down),
    .rotate    (rotate),
    .held      (held)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  assign pulses = {move_down, move_right, move_left, rotate};

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] pulses;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Monitor: flags overdue expectations, then matches any presented pulse.
  always @(negedge CLOCK_50) begin
    exp_t e;
    while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_pulse: at cycle %0d nothing seen, required %b at cycle %0d", cyc, e.pulses, e.cyc);
    end
    if (pulses != 4'b0000) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: cycle %0d got %b, required none", cyc, pulses);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.pulses != pulses) begin
          errors++;
          $display("FAIL pulse: cycle %0d got %b, required %b at cycle %0d", cyc, pulses, e.pulses, e.cyc);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic expect_pulse(input int c, input logic [3:0] p);
    exp_t e;
    e.cyc    = c;
    e.pulses = p;
    exp_q.push_back(e);
  endtask

  task automatic check_eq(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: cycle %0d got %b, required %b", name, cyc, act, req);
    end
  endtask

  int t0;
  int t1;

  initial begin
    // Reset, then idle
    reset = 1'b1;
    KEY   = 4'hF;
    tick(3);
    check_eq("reset_pulses", pulses, 4'b0000);
    check_eq("reset_held", held, 4'b0000);
    reset = 1'b0;
    tick(50);
    check_eq("idle_held", held, 4'b0000);

    // Short left press: single pulse, held high then low
    t0 = cyc;
    KEY[1] = 1'b0;
    expect_pulse(t0 + LAT, 4'b0010);
    tick(9);
    check_eq("left_held_high", held, 4'b0010);
    tick(1);
    KEY[1] = 1'b1;
    tick(2000);
    check_eq("left_held_low", held, 4'b0000);

    // Right glitch shorter than the debounce window
    KEY[2] = 1'b0;
    tick(3);
    KEY[2] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      check_eq("glitch_held", held, 4'b0000);
      tick(1);
    end

    // Left held 60 cycles
    t0 = cyc;
    KEY[1] = 1'b0;
    expect_pulse(t0 + LAT, 4'b0010);
`ifdef KEY_AUTOREPEAT_EN
    for (int k = 0; k < 8; k++) expect_pulse(t0 + LAT + int'(DAS) + k * int'(ARR), 4'b0010);
`endif
    tick(60);
    check_eq("left_long_held", held, 4'b0010);
    KEY[1] = 1'b1;
    tick(30);
    check_eq("left_long_released", held, 4'b0000);

    // Left and right together; right released after 40, left after 80
    t0 = cyc;
    KEY[2:1] = 2'b00;
    expect_pulse(t0 + LAT, 4'b0110);
`ifdef KEY_AUTOREPEAT_EN
    for (int k = 0; k < 4; k++) expect_pulse(t0 + 67 + k * int'(ARR), 4'b0010);
`endif
    tick(40);
    check_eq("both_held", held, 4'b0110);
    KEY[2] = 1'b1;
    tick(40);
    check_eq("left_only_held", held, 4'b0010);
    KEY[1] = 1'b1;
    tick(30);
    check_eq("both_released", held, 4'b0000);

    // Rotate held: one pulse only
    t0 = cyc;
    KEY[0] = 1'b0;
    expect_pulse(t0 + LAT, 4'b0001);
    tick(60);
    check_eq("rotate_held", held, 4'b0001);
    KEY[0] = 1'b1;
    tick(20);

    // Down held into repeat, reset mid-hold, key still pressed afterwards
    t0 = cyc;
    KEY[3] = 1'b0;
    expect_pulse(t0 + LAT, 4'b1000);
`ifdef KEY_AUTOREPEAT_EN
    for (int k = 0; k < 3; k++) expect_pulse(t0 + LAT + int'(DAS) + k * int'(ARR), 4'b1000);
`endif
    tick(40);
    reset = 1'b1;
    tick(1);
    check_eq("midreset_pulses", pulses, 4'b0000);
    check_eq("midreset_held", held, 4'b0000);
    tick(2);
    reset = 1'b0;
    t1 = cyc;
    expect_pulse(t1 + LAT, 4'b1000);
    tick(10);
    check_eq("post_reset_held", held, 4'b1000);
    KEY[3] = 1'b1;
    tick(30);
    check_eq("final_held", held, 4'b0000);

    tick(5);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected: %0d pulses still pending, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
